// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants and FSM state type for the iir sample feeder
package iir_pkg;
   localparam int DEFAULT_DATA_W = 8;
   localparam logic signed [7:0] IMPULSE_AMP = 8'sh7F;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      IMP_ISSUE = 2'd1,
      IMP_DRAIN = 2'd2
   } feeder_state_e;
endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO, head visible combinationally, no write-to-read bypass
module sample_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [AW:0]       level_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   // Pointers carry one extra MSB so full and empty differ only in that bit.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = data_i;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/iir_sample_feeder.sv
// rtl/iir_sample_feeder.sv - buffers samples into iir_filter and runs impulse-response sequences
module iir_sample_feeder
   import iir_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 4,
   parameter int LEN_W  = 9
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [DATA_W-1:0]      s_data_i,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   output logic [DATA_W-1:0]      d_o,
   output logic                   en_o,
   input  logic                   busy_i,
   input  logic                   valid_i,
   input  logic                   imp_start_i,
   input  logic [LEN_W-1:0]       imp_len_i,
   output logic                   imp_busy_o,
   output logic                   done_o,
   output logic [$clog2(DEPTH):0] level_o
);
   feeder_state_e     state_q, state_d;
   logic [LEN_W-1:0]  out_q, out_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  iss_q, iss_d;
   logic [LEN_W-1:0]  res_q, res_d;
   logic [LEN_W-1:0]  res_next;
   logic              done_q, done_d;
   logic              en, pop;
   logic [DATA_W-1:0] d_mux;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;

   sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (s_valid_i),
      .data_i  (s_data_i),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   always_comb begin
      en       = 1'b0;
      pop      = 1'b0;
      d_mux    = '0;
      state_d  = state_q;
      len_d    = len_q;
      iss_d    = iss_q;
      res_d    = res_q;
      res_next = res_q + LEN_W'(valid_i);
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            en  = !fifo_empty && !busy_i;
            pop = en;
            if (en) begin
               d_mux = fifo_head;
            end
            // Impulse runs need a quiet pipeline; a start seen at any other time is dropped.
            if (imp_start_i && fifo_empty && (out_q == '0) && !busy_i) begin
               len_d   = (imp_len_i == '0) ? LEN_W'(1) : imp_len_i;
               iss_d   = '0;
               res_d   = '0;
               state_d = IMP_ISSUE;
            end
         end
         IMP_ISSUE: begin
            en = !busy_i;
            if (en) begin
               d_mux = (iss_q == '0) ? DATA_W'(IMPULSE_AMP) : '0;
               iss_d = iss_q + LEN_W'(1);
               if ((iss_q + LEN_W'(1)) == len_q) begin
                  state_d = IMP_DRAIN;
               end
            end
            res_d = res_next;
         end
         IMP_DRAIN: begin
            res_d = res_next;
            if (res_next == len_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_d = out_q;
      if (en && !valid_i) begin
         out_d = out_q + LEN_W'(1);
      end else if (!en && valid_i && (out_q != '0)) begin
         out_d = out_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         out_q   <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign en_o       = en;
   assign d_o        = d_mux;
   assign s_ready_o  = !fifo_full;
   assign imp_busy_o = (state_q != IDLE);
   assign done_o     = done_q;
endmodule
